sdram_cpu_req_bridge: RTL and testbench

//  Upstream request bridge for the CPU port of the NES SDRAM controller.

---
 rtl/sdram_cpu_req_bridge_if.sv | 25 ++
 rtl/sdram_cpu_req_bridge.sv | 183 ++++++++++++++++++
 tb/tb_sdram_cpu_req_bridge.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cpu_req_bridge_if.sv
// CPU-side request/response bundle of the SDRAM CPU request bridge.
// The CPU drives the master modport and the bridge uses the slave modport.
interface sdram_cpu_req_bridge_if #(
  parameter int ADDR_DEPTH = 23
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_DEPTH-1:0] req_addr;
  logic [7:0]            req_wdata;
  logic                  rsp_valid;
  logic                  rsp_we;
  logic                  rsp_err;
  logic [7:0]            rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/sdram_cpu_req_bridge.sv
// Queues CPU requests and replays them into the SDRAM controller's 24-cycle slot,
// returning one response per request (or an error response when sync aborts it).
module sdram_cpu_req_bridge #(
  parameter int ADDR_DEPTH = 23,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync,
  input  logic                  ctrl_rdy,
  sdram_cpu_req_bridge_if.slave cpu,
  output logic [ADDR_DEPTH-1:0] ctrl_addr,
  output logic [7:0]            ctrl_data_wr,
  output logic                  ctrl_rd,
  output logic                  ctrl_wr,
  input  logic [7:0]            ctrl_data_rd,
  output logic                  busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 1 + ADDR_DEPTH + 8;

  localparam logic [4:0] LAST_CYCLE  = 5'd23;
  localparam logic [4:0] ISSUE_CYCLE = 5'd22;
  localparam logic [4:0] DONE_CYCLE  = 5'd8;

  typedef enum logic {
    ST_IDLE,
    ST_INFLIGHT
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            cycle_q, cycle_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_DEPTH-1:0] ctrl_addr_q, ctrl_addr_d;
  logic [7:0]            ctrl_data_wr_q, ctrl_data_wr_d;
  logic                  ctrl_rd_q, ctrl_rd_d;
  logic                  ctrl_wr_q, ctrl_wr_d;
  logic                  op_we_q, op_we_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_we_q, rsp_we_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [7:0]            rsp_rdata_q, rsp_rdata_d;

  logic [ENT_W-1:0]      mem_q [DEPTH];
  logic [ENT_W-1:0]      head;
  logic [ENT_W-1:0]      entry_in;
  logic                  head_we;
  logic [ADDR_DEPTH-1:0] head_addr;
  logic [7:0]            head_wdata;
  logic                  req_ready_int;
  logic                  push;
  logic                  pop;
  logic                  issue;

  assign req_ready_int = (count_q < CNT_W'(DEPTH));
  assign push          = cpu.req_valid && req_ready_int;
  assign entry_in      = {cpu.req_we, cpu.req_addr, cpu.req_wdata};

  assign head       = mem_q[rd_ptr_q];
  assign head_we    = head[ENT_W-1];
  assign head_addr  = head[ENT_W-2 -: ADDR_DEPTH];
  assign head_wdata = head[7:0];

  // Issue is decided on the edge that enters cycle 23, so the controller sees the request on 23.
  assign issue = (state_q == ST_IDLE) && (cycle_q == ISSUE_CYCLE) && !sync
                 && (count_q != '0) && ctrl_rdy;
  assign pop   = issue;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    ctrl_addr_d    = ctrl_addr_q;
    ctrl_data_wr_d = ctrl_data_wr_q;
    ctrl_rd_d      = 1'b0;
    ctrl_wr_d      = 1'b0;
    op_we_d        = op_we_q;
    rsp_valid_d    = 1'b0;
    rsp_we_d       = 1'b0;
    rsp_err_d      = 1'b0;
    rsp_rdata_d    = 8'h00;

    cycle_d = (sync || cycle_q == LAST_CYCLE) ? 5'd0 : cycle_q + 5'd1;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d        = ST_INFLIGHT;
          ctrl_addr_d    = head_addr;
          ctrl_data_wr_d = head_wdata;
          ctrl_rd_d      = !head_we;
          ctrl_wr_d      = head_we;
          op_we_d        = head_we;
        end
      end
      ST_INFLIGHT: begin
        // A sync restarts the controller frame, so the op is lost; report it as an error.
        if (sync) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_we_d    = op_we_q;
          rsp_err_d   = 1'b1;
        end else if (cycle_q == DONE_CYCLE) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_we_d    = op_we_q;
          rsp_rdata_d = op_we_q ? 8'h00 : ctrl_data_rd;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cycle_q        <= 5'd0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ctrl_addr_q    <= '0;
      ctrl_data_wr_q <= 8'h00;
      ctrl_rd_q      <= 1'b0;
      ctrl_wr_q      <= 1'b0;
      op_we_q        <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_we_q       <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      cycle_q        <= cycle_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ctrl_addr_q    <= ctrl_addr_d;
      ctrl_data_wr_q <= ctrl_data_wr_d;
      ctrl_rd_q      <= ctrl_rd_d;
      ctrl_wr_q      <= ctrl_wr_d;
      op_we_q        <= op_we_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_we_q       <= rsp_we_d;
      rsp_err_q      <= rsp_err_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign cpu.req_ready = req_ready_int;
  assign cpu.rsp_valid = rsp_valid_q;
  assign cpu.rsp_we    = rsp_we_q;
  assign cpu.rsp_err   = rsp_err_q;
  assign cpu.rsp_rdata = rsp_rdata_q;

  assign ctrl_addr    = ctrl_addr_q;
  assign ctrl_data_wr = ctrl_data_wr_q;
  assign ctrl_rd      = ctrl_rd_q;
  assign ctrl_wr      = ctrl_wr_q;
  assign busy         = (count_q != '0) || (state_q == ST_INFLIGHT);

endmodule

// File: tb/tb_sdram_cpu_req_bridge.sv
// Directed bench for sdram_cpu_req_bridge with a small controller read-data model.
module tb_sdram_cpu_req_bridge;

  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync;
  logic          ctrl_rdy;
  logic [AW-1:0] ctrl_addr;
  logic [7:0]    ctrl_data_wr;
  logic          ctrl_rd;
  logic          ctrl_wr;
  logic [7:0]    ctrl_data_rd;
  logic          busy;

  sdram_cpu_req_bridge_if #(.ADDR_DEPTH(AW)) cpu_if ();

  sdram_cpu_req_bridge #(.ADDR_DEPTH(AW), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sync         (sync),
    .ctrl_rdy     (ctrl_rdy),
    .cpu          (cpu_if.slave),
    .ctrl_addr    (ctrl_addr),
    .ctrl_data_wr (ctrl_data_wr),
    .ctrl_rd      (ctrl_rd),
    .ctrl_wr      (ctrl_wr),
    .ctrl_data_rd (ctrl_data_rd),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Controller frame counter and read-data model: data = addr[7:0] ^ 0x86, valid only on cycle 8.
  logic [4:0] tb_cycle = 5'd0;
  int         abs_cyc = 0;
  always @(posedge clk) begin
    abs_cyc <= abs_cyc + 1;
    if (rst || sync || tb_cycle == 5'd23) tb_cycle <= 5'd0;
    else                                  tb_cycle <= tb_cycle + 5'd1;
  end
  assign ctrl_data_rd = (tb_cycle == 5'd8) ? (ctrl_addr[7:0] ^ 8'h86) : 8'h00;

  int pulses = 0;
  int bad_pulses = 0;
  int rsp_cnt = 0;
  always @(negedge clk) begin
    if (ctrl_rd || ctrl_wr) begin
      pulses <= pulses + 1;
      if (tb_cycle != 5'd23 || (ctrl_rd && ctrl_wr)) bad_pulses <= bad_pulses + 1;
    end
    if (cpu_if.rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_we    = we;
    cpu_if.req_addr  = addr;
    cpu_if.req_wdata = wdata;
    step();
    cpu_if.req_valid = 1'b0;
  endtask

  task automatic wait_cycle(input string tag, input logic [4:0] c);
    int n = 0;
    while (tb_cycle != c && n < 30) begin
      step();
      n++;
    end
    if (tb_cycle != c) check({tag, "_timeout"}, 32'(tb_cycle), 32'(c));
  endtask

  task automatic wait_ctrl(input string tag, input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      step();
      if (ctrl_rd || ctrl_wr) seen = 1'b1;
    end
    if (!seen) check({tag, "_ctrl_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input int maxc, output int at);
    bit seen = 1'b0;
    at = -1;
    for (int i = 0; i < maxc && !seen; i++) begin
      step();
      if (cpu_if.rsp_valid) begin
        seen = 1'b1;
        at   = abs_cyc;
      end
    end
    if (!seen) check({tag, "_rsp_timeout"}, 32'(seen), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int at1, at2, at3, p0, r0, sync_at;
    rst              = 1'b1;
    sync             = 1'b0;
    ctrl_rdy         = 1'b1;
    cpu_if.req_valid = 1'b0;
    cpu_if.req_we    = 1'b0;
    cpu_if.req_addr  = '0;
    cpu_if.req_wdata = 8'h00;
    repeat (3) step();

    check("rst_req_ready", 32'(cpu_if.req_ready), 32'd1);
    check("rst_busy",      32'(busy),             32'd0);
    check("rst_ctrl_rd",   32'(ctrl_rd),          32'd0);
    check("rst_ctrl_wr",   32'(ctrl_wr),          32'd0);
    check("rst_rsp_valid", 32'(cpu_if.rsp_valid), 32'd0);
    check("rst_ctrl_addr", 32'(ctrl_addr),        32'd0);
    check("rst_rsp_rdata", 32'(cpu_if.rsp_rdata), 32'd0);
    rst = 1'b0;

    // 1: single read pushed at cycle 5
    wait_cycle("t1", 5'd5);
    push_req(1'b0, 23'h000123, 8'h00);
    check("t1_busy", 32'(busy), 32'd1);
    wait_ctrl("t1", 30);
    check("t1_issue_cycle", 32'(tb_cycle),  32'd23);
    check("t1_ctrl_rd",     32'(ctrl_rd),   32'd1);
    check("t1_ctrl_wr",     32'(ctrl_wr),   32'd0);
    check("t1_ctrl_addr",   32'(ctrl_addr), 32'h000123);
    step();
    check("t1_ctrl_rd_drop", 32'(ctrl_rd), 32'd0);
    wait_rsp("t1", 30, at1);
    check("t1_rsp_cycle", 32'(tb_cycle),         32'd9);
    check("t1_rsp_rdata", 32'(cpu_if.rsp_rdata), 32'hA5);
    check("t1_rsp_we",    32'(cpu_if.rsp_we),    32'd0);
    check("t1_rsp_err",   32'(cpu_if.rsp_err),   32'd0);
    step();
    check("t1_rsp_one_cycle", 32'(cpu_if.rsp_valid), 32'd0);
    check("t1_busy_idle",     32'(busy),             32'd0);

    // 2: write
    push_req(1'b1, 23'h000040, 8'h3C);
    wait_ctrl("t2", 30);
    check("t2_issue_cycle", 32'(tb_cycle),     32'd23);
    check("t2_ctrl_wr",     32'(ctrl_wr),      32'd1);
    check("t2_ctrl_rd",     32'(ctrl_rd),      32'd0);
    check("t2_ctrl_data",   32'(ctrl_data_wr), 32'h3C);
    check("t2_ctrl_addr",   32'(ctrl_addr),    32'h000040);
    wait_rsp("t2", 30, at1);
    check("t2_rsp_cycle", 32'(tb_cycle),         32'd9);
    check("t2_rsp_we",    32'(cpu_if.rsp_we),    32'd1);
    check("t2_rsp_rdata", 32'(cpu_if.rsp_rdata), 32'h00);
    check("t2_rsp_err",   32'(cpu_if.rsp_err),   32'd0);

    // 3: three back-to-back reads into a 2-entry FIFO
    step();
    p0 = pulses;
    cpu_if.req_valid = 1'b1;
    cpu_if.req_we    = 1'b0;
    cpu_if.req_addr  = 23'h000011;
    step();
    check("t3_ready_after1", 32'(cpu_if.req_ready), 32'd1);
    cpu_if.req_addr = 23'h000022;
    step();
    check("t3_ready_full", 32'(cpu_if.req_ready), 32'd0);
    check("t3_busy_full",  32'(busy),             32'd1);
    cpu_if.req_addr = 23'h000033;
    for (int i = 0; i < 30 && !cpu_if.req_ready; i++) step();
    check("t3_third_accept_cycle", 32'(tb_cycle), 32'd23);
    step();
    cpu_if.req_valid = 1'b0;
    wait_rsp("t3a", 30, at1);
    check("t3_rsp1_rdata", 32'(cpu_if.rsp_rdata), 32'h97);
    wait_rsp("t3b", 30, at2);
    check("t3_rsp2_rdata", 32'(cpu_if.rsp_rdata), 32'hA4);
    wait_rsp("t3c", 30, at3);
    check("t3_rsp3_rdata", 32'(cpu_if.rsp_rdata), 32'hB5);
    check("t3_gap12", 32'(at2 - at1), 32'd24);
    check("t3_gap23", 32'(at3 - at2), 32'd24);
    check("t3_pulses", 32'(pulses - p0), 32'd3);

    // 4: controller not ready for two frames
    ctrl_rdy = 1'b0;
    p0 = pulses;
    push_req(1'b0, 23'h000055, 8'h00);
    repeat (48) step();
    check("t4_no_pulse", 32'(pulses - p0), 32'd0);
    check("t4_busy",     32'(busy),        32'd1);
    ctrl_rdy = 1'b1;
    wait_ctrl("t4", 30);
    check("t4_issue_cycle", 32'(tb_cycle),  32'd23);
    check("t4_ctrl_addr",   32'(ctrl_addr), 32'h000055);
    wait_rsp("t4", 30, at1);
    check("t4_rsp_rdata", 32'(cpu_if.rsp_rdata), 32'hD3);

    // 5: sync aborts an in-flight read; the queued one issues in the restarted frame
    push_req(1'b0, 23'h000066, 8'h00);
    push_req(1'b0, 23'h000077, 8'h00);
    wait_ctrl("t5", 30);
    check("t5_first_addr", 32'(ctrl_addr), 32'h000066);
    wait_cycle("t5", 5'd4);
    sync = 1'b1;
    step();
    sync = 1'b0;
    sync_at = abs_cyc;
    check("t5_err_valid", 32'(cpu_if.rsp_valid), 32'd1);
    check("t5_err_flag",  32'(cpu_if.rsp_err),   32'd1);
    check("t5_err_rdata", 32'(cpu_if.rsp_rdata), 32'h00);
    check("t5_err_we",    32'(cpu_if.rsp_we),    32'd0);
    check("t5_busy",      32'(busy),             32'd1);
    wait_ctrl("t5b", 30);
    check("t5_reissue_delay", 32'(abs_cyc - sync_at), 32'd23);
    check("t5_second_addr",   32'(ctrl_addr),         32'h000077);
    wait_rsp("t5", 30, at1);
    check("t5_rsp_rdata", 32'(cpu_if.rsp_rdata), 32'hF1);
    check("t5_rsp_err",   32'(cpu_if.rsp_err),   32'd0);

    // 6: reset with two queued and one in flight
    push_req(1'b0, 23'h000001, 8'h00);
    push_req(1'b0, 23'h000002, 8'h00);
    wait_ctrl("t6", 30);
    push_req(1'b0, 23'h000003, 8'h00);
    wait_cycle("t6", 5'd3);
    check("t6_busy_pre", 32'(busy), 32'd1);
    r0 = rsp_cnt;
    p0 = pulses;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("t6_req_ready", 32'(cpu_if.req_ready), 32'd1);
    check("t6_busy",      32'(busy),             32'd0);
    check("t6_ctrl_rd",   32'(ctrl_rd),          32'd0);
    check("t6_ctrl_wr",   32'(ctrl_wr),          32'd0);
    repeat (60) step();
    check("t6_no_rsp",   32'(rsp_cnt - r0), 32'd0);
    check("t6_no_pulse", 32'(pulses - p0),  32'd0);

    check("pulse_timing", 32'(bad_pulses), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
